key_repeat: RTL and testbench
=============================

Name: key_repeat

Overview:
- Consumer-side companion to the push-button debouncer.
- Takes the debounced key level and turns it into user-intent events for the screen-adjustment logic:
  - one tick on press;
  - after a hold delay, auto-repeat ticks at a fixed rate;
  - a long-press flag;
  - a release tick.
- Sits between the debouncer and the adjustment counters. One instance per button.

Parameters:
- HOLD_CNT, 25_000_000, cycles from the press tick to the first repeat tick (500 ms at 50 MHz); must be ≥ 2.
- RPT_CNT, 5_000_000, cycles between successive repeat ticks (100 ms at 50 MHz); must be ≥ 2.
- CW, 25, timer width; must satisfy 2^CW ≥ max(HOLD_CNT, RPT_CNT).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_level  in  1  debounced key level, active-high, synchronous to clk.
- key_tick  out  1  one-cycle pulse on press and on every auto-repeat.
- release_tick  out  1  one-cycle pulse on release.
- long_press  out  1  high while the key is held past HOLD_CNT.
- rpt_count  out  8  repeat ticks in the current or most recent press, saturating at 255.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE, timer = 0;
  - key_tick = 0, release_tick = 0, long_press = 0, rpt_count = 0.
- All outputs are registered. No combinational input-to-output path.
- key_level is used directly with no further synchronisation.
- States: IDLE, HOLD, REPEAT.
- IDLE:
  - key_level = 1 at edge k → state HOLD, timer = 0, rpt_count = 0, key_tick = 1 for the cycle after edge k.
- HOLD:
  - key_level = 0 → release_tick = 1 next cycle, state IDLE, timer = 0.
  - Otherwise, timer = timer + 1 each cycle.
  - At an edge with timer == HOLD_CNT−1:
    - key_tick = 1, long_press = 1, rpt_count = 1;
    - timer = 0, state REPEAT.
  - Net effect: the first repeat tick comes exactly HOLD_CNT cycles after the press tick.
- REPEAT:
  - key_level = 0 → release_tick = 1, long_press = 0 next cycle, state IDLE, timer = 0.
  - Otherwise, timer increments. At timer == RPT_CNT−1:
    - key_tick = 1, timer = 0;
    - rpt_count = rpt_count + 1, saturating at 255 (holds at 255; ticks continue).
  - Net effect: repeat ticks are spaced exactly RPT_CNT cycles apart.
- Simultaneous release and timer expiry on the same edge: release wins. No key_tick; release_tick only.
- key_tick and release_tick are never high in the same cycle.
- Re-press on the edge right after release_tick (IDLE sees level 1): a new press is handled normally, so every press tick follows a release tick.
- rpt_count holds its value after release until the next press clears it.
- long_press falls in the same cycle that release_tick is high.
- Reset mid-operation (HOLD or REPEAT):
  - outputs clear immediately and asynchronously;
  - after reset release, if key_level is still 1, IDLE treats it as a new press with a fresh key_tick.
- Illegal state encoding → IDLE on the next edge, outputs at reset values.
- The timer never exceeds max(HOLD_CNT, RPT_CNT)−1. No wrap-around in any state.

Test Plan (sim parameters HOLD_CNT=10, RPT_CNT=4):
- Short press: key_level high 5 cycles, then low → exactly one key_tick (cycle after rise), one release_tick, long_press never high, rpt_count = 0.
- Long hold: key_level high 25 cycles → key_tick at +1, +11, +15, +19, +23 cycles after rise; long_press high from +11; rpt_count = 4; release_tick 1 cycle after fall; long_press low the same cycle as release_tick.
- Release collision: key_level falls exactly on the edge where timer == 9 in HOLD → no second key_tick, release_tick = 1, long_press stays 0.
- Saturation: hold for 10 + 4×300 cycles → rpt_count stops at 255 while key_tick keeps pulsing every 4 cycles.
- Async reset mid-REPEAT: assert rst_n low between edges → all outputs 0 immediately. Deassert with key_level = 1 → key_tick 1 cycle later, rpt_count = 0.
- Back-to-back presses: high 3, low 1, high 3 → pulse order is key_tick, release_tick, key_tick, release_tick; never overlapping.

Source files
------------

// File: rtl/key_repeat.sv
// Key auto-repeat: converts a debounced key level into a press tick, delayed
// auto-repeat ticks, a long-press flag, a release tick and a repeat count.
module key_repeat #(
  parameter int unsigned HOLD_CNT = 25_000_000,
  parameter int unsigned RPT_CNT  = 5_000_000,
  parameter int unsigned CW       = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_level,
  output logic       key_tick,
  output logic       release_tick,
  output logic       long_press,
  output logic [7:0] rpt_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CNT - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CNT - 1);

  state_t        state, state_n;
  logic [CW-1:0] timer, timer_n;
  logic          key_tick_n;
  logic          release_tick_n;
  logic          long_press_n;
  logic [7:0]    rpt_count_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      key_tick     <= 1'b0;
      release_tick <= 1'b0;
      long_press   <= 1'b0;
      rpt_count    <= '0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      key_tick     <= key_tick_n;
      release_tick <= release_tick_n;
      long_press   <= long_press_n;
      rpt_count    <= rpt_count_n;
    end
  end

  always_comb begin
    state_n        = state;
    timer_n        = timer;
    key_tick_n     = 1'b0;
    release_tick_n = 1'b0;
    long_press_n   = long_press;
    rpt_count_n    = rpt_count;

    unique case (state)
      IDLE: begin
        timer_n      = '0;
        long_press_n = 1'b0;
        if (key_level) begin
          state_n     = HOLD;
          rpt_count_n = '0;
          key_tick_n  = 1'b1;
        end
      end

      HOLD: begin
        // Release is tested first so it wins over a coincident expiry.
        if (!key_level) begin
          state_n        = IDLE;
          timer_n        = '0;
          release_tick_n = 1'b1;
          long_press_n   = 1'b0;
        end else if (timer == HOLD_LAST) begin
          state_n      = REPEAT;
          timer_n      = '0;
          key_tick_n   = 1'b1;
          long_press_n = 1'b1;
          rpt_count_n  = 8'd1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      REPEAT: begin
        if (!key_level) begin
          state_n        = IDLE;
          timer_n        = '0;
          release_tick_n = 1'b1;
          long_press_n   = 1'b0;
        end else if (timer == RPT_LAST) begin
          timer_n    = '0;
          key_tick_n = 1'b1;
          if (rpt_count != 8'hFF) begin
            rpt_count_n = rpt_count + 8'd1;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      default: begin
        state_n      = IDLE;
        timer_n      = '0;
        long_press_n = 1'b0;
        rpt_count_n  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_repeat.sv
// Directed bench for key_repeat with HOLD_CNT=10, RPT_CNT=4: vector table
// for short/back-to-back/collision/long-hold, plus saturation and async reset.
module tb_key_repeat;

  logic       clk;
  logic       rst_n;
  logic       key_level;
  logic       key_tick;
  logic       release_tick;
  logic       long_press;
  logic [7:0] rpt_count;

  int n_cmp = 0;
  int n_bad = 0;

  key_repeat #(
    .HOLD_CNT (10),
    .RPT_CNT  (4),
    .CW       (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_level    (key_level),
    .key_tick     (key_tick),
    .release_tick (release_tick),
    .long_press   (long_press),
    .rpt_count    (rpt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       key;
    logic       kt;
    logic       rt;
    logic       lp;
    logic [7:0] rc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic k, input logic kt, input logic rt,
                              input logic lp, input logic [7:0] rc);
    vec_t v;
    v.key = k; v.kt = kt; v.rt = rt; v.lp = lp; v.rc = rc;
    vecs.push_back(v);
  endfunction

  function automatic logic [10:0] outs();
    return {key_tick, release_tick, long_press, rpt_count};
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got kt=%b rt=%b lp=%b rc=%0d, expected kt=%b rt=%b lp=%b rc=%0d",
               name, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic step(input logic k);
    key_level = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ekt;
    logic [7:0]  erc;
    int          r;

    // Short press: 5 high, then low
    add(1, 1, 0, 0, 0);
    repeat (4) add(1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0);
    // Back-to-back: high 3, low 1, high 3
    add(1, 1, 0, 0, 0); add(1, 0, 0, 0, 0); add(1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0); add(1, 0, 0, 0, 0); add(1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0);
    // Release on the edge where the hold timer would expire
    add(1, 1, 0, 0, 0);
    repeat (9) add(1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0);
    // Long hold of 25 cycles: ticks at +1, +11, +15, +19, +23
    for (int s = 1; s <= 25; s++) begin
      add(1, (s == 1 || s == 11 || s == 15 || s == 19 || s == 23), 0, (s >= 11),
          (s < 11) ? 8'd0 : 8'((s - 11) / 4 + 1));
    end
    add(0, 0, 1, 0, 4);
    add(0, 0, 0, 0, 4);

    rst_n     = 1'b0;
    key_level = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", outs(), 11'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].key);
      check($sformatf("vec%0d", i), outs(), {vecs[i].kt, vecs[i].rt, vecs[i].lp, vecs[i].rc});
    end

    // Saturation: hold 10 + 4*300 cycles past the press tick
    for (int s = 1; s <= 1210; s++) begin
      step(1'b1);
      ekt = (s == 1) || (s >= 11 && ((s - 11) % 4) == 0);
      r   = (s < 11) ? 0 : ((s - 11) / 4 + 1);
      erc = (r > 255) ? 8'd255 : 8'(r);
      check($sformatf("sat_s%0d", s), outs(), {ekt, 1'b0, (s >= 11), erc});
    end
    step(1'b0);
    check("sat_release", outs(), {1'b0, 1'b1, 1'b0, 8'd255});
    step(1'b0);
    check("sat_idle", outs(), {1'b0, 1'b0, 1'b0, 8'd255});

    // Async reset in REPEAT, key still held through reset release
    for (int s = 1; s <= 16; s++) step(1'b1);
    check("pre_reset_repeat", outs(), {1'b0, 1'b0, 1'b1, 8'd2});
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", outs(), 11'd0);
    @(posedge clk);
    #3;
    check("reset_held", outs(), 11'd0);
    rst_n = 1'b1;
    step(1'b1);
    check("post_reset_press", outs(), {1'b1, 1'b0, 1'b0, 8'd0});
    step(1'b1);
    check("post_reset_hold", outs(), {1'b0, 1'b0, 1'b0, 8'd0});
    step(1'b0);
    check("post_reset_release", outs(), {1'b0, 1'b1, 1'b0, 8'd0});
    step(1'b0);
    check("post_reset_idle", outs(), {1'b0, 1'b0, 1'b0, 8'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
